// File: rtl/dq_pi_ctrl_pkg.sv
// Shared FOC definitions: PI sequencer states, fixed-point widths and the
// symmetric saturation helper used by the d/q current regulator.
package foc_pkg;

    // Sequencer states of the time-shared PI regulator
    typedef enum logic [2:0] {
        PI_IDLE  = 3'd0,
        PI_ERR   = 3'd1,
        PI_MUL_D = 3'd2,
        PI_ACC_D = 3'd3,
        PI_MUL_Q = 3'd4,
        PI_ACC_Q = 3'd5,
        PI_OUT   = 3'd6
    } pi_state_t;

    // Fractional bits of kp (Q8.8) and ki (Q0.16), integrator width
    localparam int KP_FRAC = 8;
    localparam int KI_FRAC = 16;
    localparam int ACC_W   = 36;

    // Working width for sums before saturation; wide enough for any
    // accumulator + product or proportional + integral combination.
    localparam int SAT_W = 40;

    // Clamp value into [-limit, +limit]; limit is expected to be positive.
    function automatic logic signed [SAT_W-1:0] sat_s(
        input logic signed [SAT_W-1:0] value,
        input logic signed [SAT_W-1:0] limit
    );
        if (value > limit) begin
            return limit;
        end else if (value < -limit) begin
            return -limit;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/dq_pi_ctrl_if.sv
// Sample/result bus between park_tr (master) and the d/q PI regulator (slave).
// The master presents a measured/target current set with a one-cycle i_en;
// the slave returns voltage commands with a one-cycle o_en.
interface dq_pi_if;

    logic               i_en;
    logic signed [15:0] i_id;
    logic signed [15:0] i_iq;
    logic signed [15:0] i_id_aim;
    logic signed [15:0] i_iq_aim;

    logic               o_en;
    logic signed [15:0] o_vd;
    logic signed [15:0] o_vq;

    modport master (
        output i_en, i_id, i_iq, i_id_aim, i_iq_aim,
        input  o_en, o_vd, o_vq
    );

    modport slave (
        input  i_en, i_id, i_iq, i_id_aim, i_iq_aim,
        output o_en, o_vd, o_vq
    );

endinterface

// File: rtl/dq_pi_ctrl_mac.sv
// Registered 17x17 signed multiplier pair. Both products share the same
// error operand: one against kp, one against ki. The d and q axes take
// turns on this block, selected by the sequencer in dq_pi_ctrl.
module pi_mac (
    input  logic               clk,
    input  logic               i_ce,
    input  logic signed [16:0] i_a,
    input  logic signed [16:0] i_b,
    input  logic signed [16:0] i_c,
    output logic signed [33:0] o_ab,
    output logic signed [33:0] o_ac
);

    logic signed [33:0] w_a_ext;
    logic signed [33:0] w_b_ext;
    logic signed [33:0] w_c_ext;
    logic signed [33:0] r_ab_p1;
    logic signed [33:0] r_ac_p1;

    // Operands widened to full product width so the multiply is exact
    assign w_a_ext = 34'(i_a);
    assign w_b_ext = 34'(i_b);
    assign w_c_ext = 34'(i_c);

    // Product registers, updated only when the sequencer is in a MUL state
    always_ff @(posedge clk) begin
        if (i_ce) begin
            r_ab_p1 <= w_a_ext * w_b_ext;
            r_ac_p1 <= w_a_ext * w_c_ext;
        end
    end

    assign o_ab = r_ab_p1;
    assign o_ac = r_ac_p1;

endmodule

// File: rtl/dq_pi_ctrl.sv
// Dual-axis PI current regulator. Takes one Id/Iq sample plus targets and
// produces saturated Vd/Vq commands seven edges later. A single multiplier
// pair is shared between the axes by a fixed sequencer; the integrators are
// clamped for anti-windup and can be cleared at any time with i_clr.
module dq_pi_ctrl
    import foc_pkg::*;
#(
    parameter int OUT_LIMIT = 30000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic [15:0] i_kp,
    input  logic [15:0] i_ki,
    dq_pi_if.slave      bus
);

    // Output clamp and matching integrator clamp (same value in acc units)
    localparam logic signed [SAT_W-1:0] V_LIM   = SAT_W'(OUT_LIMIT);
    localparam logic signed [SAT_W-1:0] ACC_LIM = V_LIM <<< KI_FRAC;

    pi_state_t                r_state;

    // Sample captured on the accepted i_en
    logic signed [15:0]       r_id;
    logic signed [15:0]       r_iq;
    logic signed [15:0]       r_aim_d;
    logic signed [15:0]       r_aim_q;
    logic [15:0]              r_kp;
    logic [15:0]              r_ki;

    // Control errors, integrators, per-axis results and outputs
    logic signed [16:0]       r_err_d;
    logic signed [16:0]       r_err_q;
    logic signed [ACC_W-1:0]  r_acc_d;
    logic signed [ACC_W-1:0]  r_acc_q;
    logic signed [15:0]       r_v_d;
    logic signed [15:0]       r_v_q;
    logic signed [15:0]       r_o_vd;
    logic signed [15:0]       r_o_vq;
    logic                     r_o_en;

    // Shared multiplier connections
    logic                     w_mac_ce;
    logic signed [16:0]       w_mac_err;
    logic signed [16:0]       w_mac_kp;
    logic signed [16:0]       w_mac_ki;
    logic signed [33:0]       w_p;
    logic signed [33:0]       w_m;

    // Accumulate / output datapath for whichever axis is in its ACC state
    logic signed [ACC_W-1:0]  w_acc_cur;
    logic signed [SAT_W-1:0]  w_acc_sum;
    logic signed [ACC_W-1:0]  w_acc_nx;
    logic signed [SAT_W-1:0]  w_v_sum;
    logic signed [15:0]       w_v;
    logic                     w_accept;

    // A sample is taken only from IDLE; i_clr does not block acceptance
    assign w_accept = (r_state == PI_IDLE) && bus.i_en;

    // The q error feeds the multiplier only during MUL_Q; d otherwise
    assign w_mac_ce  = (r_state == PI_MUL_D) || (r_state == PI_MUL_Q);
    assign w_mac_err = (r_state == PI_MUL_Q) ? r_err_q : r_err_d;
    assign w_mac_kp  = signed'({1'b0, r_kp});
    assign w_mac_ki  = signed'({1'b0, r_ki});

    pi_mac u_mac (
        .clk  (clk),
        .i_ce (w_mac_ce),
        .i_a  (w_mac_err),
        .i_b  (w_mac_kp),
        .i_c  (w_mac_ki),
        .o_ab (w_p),
        .o_ac (w_m)
    );

    // Integrator step with anti-windup clamp; the clamped value is also what
    // the output sum uses, so the command recovers as soon as error reverses.
    assign w_acc_cur = (r_state == PI_ACC_Q) ? r_acc_q : r_acc_d;
    assign w_acc_sum = SAT_W'(w_acc_cur) + SAT_W'(w_m);
    assign w_acc_nx  = ACC_W'(sat_s(w_acc_sum, ACC_LIM));

    // Arithmetic shifts floor toward -inf before the output clamp
    assign w_v_sum = (SAT_W'(w_p) >>> KP_FRAC) + (SAT_W'(w_acc_nx) >>> KI_FRAC);
    assign w_v     = 16'(sat_s(w_v_sum, V_LIM));

    // Sequencer, integrators and output registers; i_clr aborts and zeroes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PI_IDLE;
            r_acc_d <= '0;
            r_acc_q <= '0;
            r_o_vd  <= '0;
            r_o_vq  <= '0;
            r_o_en  <= 1'b0;
        end else begin
            r_o_en <= 1'b0;
            if (i_clr) begin
                r_acc_d <= '0;
                r_acc_q <= '0;
                r_state <= w_accept ? PI_ERR : PI_IDLE;
            end else begin
                case (r_state)
                    PI_IDLE: begin
                        if (bus.i_en) begin
                            r_state <= PI_ERR;
                        end
                    end
                    PI_ERR: begin
                        r_state <= PI_MUL_D;
                    end
                    PI_MUL_D: begin
                        r_state <= PI_ACC_D;
                    end
                    PI_ACC_D: begin
                        r_acc_d <= w_acc_nx;
                        r_state <= PI_MUL_Q;
                    end
                    PI_MUL_Q: begin
                        r_state <= PI_ACC_Q;
                    end
                    PI_ACC_Q: begin
                        r_acc_q <= w_acc_nx;
                        r_state <= PI_OUT;
                    end
                    PI_OUT: begin
                        r_o_vd  <= r_v_d;
                        r_o_vq  <= r_v_q;
                        r_o_en  <= 1'b1;
                        r_state <= PI_IDLE;
                    end
                    default: begin
                        r_state <= PI_IDLE;
                    end
                endcase
            end
        end
    end

    // Datapath registers: sample capture, errors and per-axis results
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_id    <= bus.i_id;
            r_iq    <= bus.i_iq;
            r_aim_d <= bus.i_id_aim;
            r_aim_q <= bus.i_iq_aim;
            r_kp    <= i_kp;
            r_ki    <= i_ki;
        end
        if (r_state == PI_ERR) begin
            r_err_d <= 17'(r_aim_d) - 17'(r_id);
            r_err_q <= 17'(r_aim_q) - 17'(r_iq);
        end
        if (r_state == PI_ACC_D) begin
            r_v_d <= w_v;
        end
        if (r_state == PI_ACC_Q) begin
            r_v_q <= w_v;
        end
    end

    assign bus.o_en = r_o_en;
    assign bus.o_vd = r_o_vd;
    assign bus.o_vq = r_o_vq;

endmodule

// File: doc/dq_pi_ctrl.md
# dq_pi_ctrl

Dual-axis PI current regulator sitting directly downstream of `park_tr`. It consumes each Id/Iq sample together with the d/q current targets and produces saturated Vd/Vq voltage commands for the inverse-Park/SVPWM stage. One multiplier pair is time-shared between the d and q axes, with a fixed-latency sequencer. Integrator anti-windup and a runtime integrator clear are included.

## Interface
- `OUT_LIMIT`, default 30000: symmetric output clamp (±OUT_LIMIT) for o_vd/o_vq; legal range 1..32767.
- `clk`  in  1  system clock (36.864 MHz in the FOC build).
- `rst`  in  1  asynchronous, active-high reset; one clock domain only.
- `i_clr`  in  1  synchronous integrator clear / abort.
- `i_kp`  in  16  unsigned proportional gain, Q8.8 (256 = 1.0).
- `i_ki`  in  16  unsigned integral gain per sample, Q0.16 (32768 = 0.5).
- `i_id_aim`, `i_iq_aim`  in  16 signed  current targets.
- `i_en`  in  1  sample strobe (single-cycle pulse from park_tr o_en).
- `i_id`, `i_iq`  in  16 signed  measured currents.
- `o_en`  out  1  one-cycle result strobe.
- `o_vd`, `o_vq`  out  16 signed  voltage commands, held between strobes.

## Operation
- Sequencer states: IDLE, ERR, MUL_D, ACC_D, MUL_Q, ACC_Q, OUT.
- IDLE: when i_en=1, latch i_id, i_iq, both aims, i_kp and i_ki, then go to ERR. Every other state advances unconditionally to the next one; OUT returns to IDLE.
- i_en while not in IDLE: ignored; no queueing.
- ERR: err_d = aim_d − id and err_q = aim_q − iq, both 17-bit signed and exact.
- MUL_x: p = err_x·kp (34-bit signed) and m = err_x·ki (34-bit signed), computed with a shared multiplier pair.
- ACC_x, integrator:
  - acc_x (36-bit signed) = clamp(acc_x + m, ±(OUT_LIMIT<<16)).
  - The clamp is the anti-windup.
- ACC_x, output:
  - v_x = clamp((p>>>8) + (acc_x>>>16), ±OUT_LIMIT), using the new acc_x.
  - Shifts are arithmetic, so results floor toward −∞.
- OUT: o_vd/o_vq are loaded and o_en pulses.
- i_clr=1 in any state:
  - zero acc_d and acc_q;
  - abort any computation in progress and go to IDLE, with no o_en for the aborted sample;
  - o_vd/o_vq keep their last values.
- i_clr and i_en together in IDLE: integrators are cleared and the sample is still accepted, computed with acc = 0.
- Reset: state = IDLE; acc_d, acc_q, o_vd, o_vq = 0; o_en = 0.

## Timing
- Latency: i_en sampled at edge N gives o_en = 1 during the cycle after edge N+6. o_vd/o_vq change on that same edge.
- o_en is exactly one cycle wide.
- Minimum i_en spacing is 7 cycles; park_tr's 10-cycle cadence is supported.
- Gains are captured on the accepted i_en, so gain changes mid-computation do not affect that sample.
- The integrator state persists across samples until i_clr or rst.
- Asserting rst mid-operation aborts immediately (asynchronous). No o_en follows until a new i_en arrives after rst is released.

## Structure
- Shared package `foc_pkg`:
  - state enum `pi_state_t`;
  - constants KP_FRAC = 8, KI_FRAC = 16, ACC_W = 36;
  - function `sat_s(value, limit)` for symmetric saturation.
- Sub-module `pi_mac`: registered 17×17 signed multiplier pair with an enable, instantiated once and shared by the d and q axes.
- All other logic lives in `dq_pi_ctrl`.

## Test plan
- **P only:** kp=256, ki=0, aim_d=1000, id=0, aim_q=−500, iq=0 → o_vd=1000, o_vq=−500, with o_en 7 edges after i_en.
- **Output saturation:** kp=256, aim_d=32767, id=−32768 → o_vd=30000. With the signs mirrored → o_vd=−30000.
- **Integrator steps:** kp=0, ki=32768, err_d=100 for three samples → o_vd = 50, 100, 150. Then err_d=−1 → o_vd=149 (floor).
- **Anti-windup:**
  - kp=0, ki=65535, err_d=32767, repeated 100 samples → o_vd stays at 30000.
  - Then err_d=−32767: o_vd drops below 30000 on the first sample, with no recovery lag.
- **Clear/abort:**
  - i_clr pulsed 3 cycles after i_en → no o_en for that sample, and the integrator is zeroed.
  - The next sample with kp=0 gives o_vd = (err·ki)>>>16 only.
- **Busy drop and reset:**
  - A second i_en 3 cycles after the first → exactly one o_en.
  - rst asserted mid-computation → all outputs 0, state IDLE, and normal operation on the next i_en.
